// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: shared types for the data-memory access unit.
//   size_e     - transfer size encoding (byte/half/word/dword)
//   state_e    - access controller FSM states
//   bytes_of() - number of bytes moved for a given size code
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load-data extractor.
// Shifts the selected lanes of a memory word down to bit 0, keeps
// bytes_of(size) bytes and sign- or zero-extends to DATA_W.
// Ports:
//   rdata    in  DATA_W  raw memory word
//   offset   in  OFF_W   byte offset of the access inside the word
//   size     in  2       size code (see mem_access_pkg::size_e)
//   sign_ext in  1       1 = sign-extend, 0 = zero-extend
//   ext_data out DATA_W  right-justified, extended load data
module load_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext_data
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] top_bit;
  logic [6:0]        nbits;
  logic              neg;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    nbits   = {bytes_of(size), 3'b000};
    // A full-width access cannot build its mask with a shift (it would overflow).
    if (nbits >= 7'(DATA_W)) keep_mask = '1;
    else                     keep_mask = (ONE << nbits) - ONE;
    top_bit  = keep_mask & ~(keep_mask >> 1);
    neg      = sign_ext && (|(shifted & top_bit));
    ext_data = (shifted & keep_mask) | (neg ? ~keep_mask : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: DM-stage access controller for a fixed-latency,
// word-wide data memory. One outstanding request; valid/ready on both
// the request and the response side; byte/half/word/dword with lane
// masking, sign/zero extension and misalignment detection.
//
// Optional build macro: MEM_ACCESS_STATS_EN adds 32-bit wrapping
// counters stat_loads / stat_stores / stat_errs (bumped on the response
// handshake of each access type).
//
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata - core request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                             - core response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wmask/mem_rdata              - memory side
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | req_ready high, waiting for a request
// ST_ISSUE | single cycle with mem_en high, address/data/mask driven
// ST_WAIT  | load in flight, counter counts down to the rdata cycle
// ST_RESP  | rsp_valid high, held until rsp_ready
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]         stat_loads,
  output logic [31:0]         stat_stores,
  output logic [31:0]         stat_errs
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e            state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [OFF_W-1:0]  r_off;
  logic [CNT_W-1:0]  cnt;

  logic [2:0]        align_bits;
  logic              illegal;
  logic [NB-1:0]     lane_fill;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] ext_data;

  always_comb begin
    align_bits = 3'(bytes_of(req_size) - 4'd1);
    illegal    = (|(req_addr[2:0] & align_bits)) ||
                 ((DATA_W == 32) && (req_size == SZ_D));
    if (bytes_of(req_size) >= 4'(NB)) lane_fill = '1;
    else lane_fill = (NB'(1) << bytes_of(req_size)) - NB'(1);
    lane_mask = lane_fill << req_addr[OFF_W-1:0];
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata    (mem_rdata),
    .offset   (r_off),
    .size     (r_size),
    .sign_ext (r_signed),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      r_we      <= 1'b0;
      r_size    <= 2'd0;
      r_signed  <= 1'b0;
      r_off     <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_off     <= req_addr[OFF_W-1:0];
            req_ready <= 1'b0;
            if (illegal) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              // Memory-side outputs are registered here so ISSUE drives them glitch-free.
              state     <= ST_ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata <= req_wdata << {req_addr[OFF_W-1:0], 3'b000};
              mem_wmask <= req_we ? lane_mask : '0;
            end
          end
        end
        ST_ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wmask <= '0;
          if (r_we) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state <= ST_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          // Terminal count lines up with the cycle mem_rdata is valid.
          if (cnt == '0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ext_data;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state == ST_RESP && rsp_ready) begin
      if (rsp_err)   stat_errs   <= stat_errs + 32'd1;
      else if (r_we) stat_stores <= stat_stores + 32'd1;
      else           stat_loads  <= stat_loads + 32'd1;
    end
  end
`endif

endmodule
